// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith plus iterative MUL/DIVU/REMU.
// All results are registered behind a valid/ready handshake.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [3:0]       op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] acc_n, x_n, y_n, fin;
  logic [WIDTH:0]   sh, tr;
  logic             ge;
  logic             last;

  logic [WIDTH-1:0]   sc_res, sum, diff;
  logic               sc_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic               is_iter;

  assign sum   = operand_a + operand_b;
  assign diff  = operand_a - operand_b;
  assign shamt = operand_b[SHAMT_W-1:0];
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  assign is_iter = (alu_ctrl == OP_MUL) ||
                   (((alu_ctrl == OP_DIVU) ||
                     (alu_ctrl == OP_REMU)) &&
                    (operand_b != '0));

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND:  sc_res = operand_a & operand_b;
      OP_OR:   sc_res = operand_a | operand_b;
      OP_XOR:  sc_res = operand_a ^ operand_b;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                 (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                 (diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SLL:  sc_res = operand_a << shamt;
      OP_SRL:  sc_res = operand_a >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(operand_a) >>> shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      // only reached here when the divisor is zero
      OP_DIVU: sc_res = '1;
      OP_REMU: sc_res = operand_a;
      default: sc_res = '0;
    endcase
  end

  // MUL: acc += x when y[0]; DIV: y shifts dividend out, quotient in
  always_comb begin
    sh    = {acc, y[WIDTH-1]};
    tr    = sh - {1'b0, x};
    ge    = ~tr[WIDTH];
    acc_n = acc;
    x_n   = x;
    y_n   = y;
    if (op == OP_MUL) begin
      acc_n = acc + (y[0] ? x : '0);
      x_n   = x << 1;
      y_n   = y >> 1;
    end else begin
      acc_n = ge ? tr[WIDTH-1:0] : sh[WIDTH-1:0];
      y_n   = {y[WIDTH-2:0], ge};
    end
    fin = (op == OP_DIVU) ? y_n : acc_n;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = is_iter ? BUSY : DONE;
      BUSY: if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      cnt      <= '0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op  <= alu_ctrl;
          cnt <= '0;
          acc <= '0;
          if (alu_ctrl == OP_MUL) begin
            x <= operand_a;
            y <= operand_b;
          end else begin
            x <= operand_b;
            y <= operand_a;
          end
          if (!is_iter) begin
            result   <= sc_res;
            zero     <= (sc_res == '0);
            overflow <= sc_ovf;
          end
        end
        BUSY: begin
          acc <= acc_n;
          x   <= x_n;
          y   <= y_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            result   <= fin;
            zero     <= (fin == '0);
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Parametrised successor to the single-cycle datapath ALU. It uses the same 4-bit ALU control encoding and extends it with logic, shift, compare, multiply and divide operations. It registers every result behind a valid/ready handshake. Multiply and divide are iterative (one bit per cycle), so the core can stall the pipeline through the handshake instead of using a combinational array.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from operand_b

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
alu_ctrl  input  4  operation code (see Behaviour)
operand_a  input  WIDTH  first operand (ReadData1 side)
operand_b  input  WIDTH  second operand (ReadData2/immediate already muxed)
out_valid  output  1  result registered and held
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (these keep the existing encoding).
  - 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU.
  - 1010 MUL (low WIDTH bits), 1011 DIVU, 1100 REMU.
  - Any other code: result 0, single-cycle.
- Shifts use operand_b[SHAMT_W-1:0] only. Upper bits are ignored.
- SLT/SLTU: result is 1 or 0, zero-extended to WIDTH.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: on a rising edge with state==IDLE && in_valid.
  - Operands and opcode are latched; later input changes are ignored.
  - Single-cycle ops and any unknown code: result computed and state->DONE on the accept edge. out_valid is high the next cycle, so latency is 1.
  - MUL: shift-add. The accept edge loads the multiplicand, multiplier, zeroed accumulator and cnt=0, and state->BUSY. Each BUSY edge performs one iteration and increments cnt. The edge with cnt==WIDTH-1 writes result and state->DONE. Latency is WIDTH+1 edges after accept.
  - DIVU/REMU: restoring division with a WIDTH+1-bit partial remainder. Timing is identical to MUL.
- Divide by zero (operand_b==0): no iteration; state->DONE on the accept edge.
  - DIVU result = all ones.
  - REMU result = operand_a.
- Flags:
  - zero is registered with result: zero = (result == 0) for every op.
  - overflow for ADD: operands have the same sign and the result sign differs.
  - overflow for SUB: operands have different signs and the result sign differs from operand_a.
- DONE: result, zero and overflow hold stable until out_ready. On an edge with out_valid && out_ready, state->IDLE and out_valid->0. No new request is accepted on that same edge (in_ready is 0 in DONE). Peak throughput is one op per 2 cycles.
- in_ready and out_valid are decoded directly from state, with no combinational path from in_valid/out_ready.
- Reset (rst=1 at an edge), including mid-iteration or while DONE:
  - state->IDLE, cnt->0.
  - result, zero, overflow, out_valid -> 0.
  - Internal accumulators/remainder -> 0.
  - Any operation in flight is discarded.
- in_ready is 0 while rst is high.
- BUSY ignores in_valid and out_ready.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 -> one edge after accept: out_valid=1, result=0x80000000, overflow=1, zero=0. SUB a=5 b=5 -> result 0, zero=1, overflow=0.
- Back-pressure: AND a=0xF0F0F0F0 b=0xFF00FF00 with out_ready=0 for 5 cycles -> result=0xF000F000 held constant, in_ready=0 throughout. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Shifts/compare:
  - SRA a=0x80000000 b=0x00000024 (shamt 4) -> 0xF8000000.
  - SLT a=0xFFFFFFFF b=1 -> 1.
  - SLTU with the same operands -> 0.
- MUL a=0x00012345 b=0x00000100 -> out_valid exactly WIDTH+1 (33) edges after accept, result=0x01234500. a=0xFFFFFFFF b=0xFFFFFFFF -> result=1.
- DIVU a=100 b=7 -> 14; REMU -> 2, both 33 edges after accept. DIVU a=9 b=0 -> 0xFFFFFFFF after 1 edge; REMU a=9 b=0 -> 9 after 1 edge.
- Assert rst at BUSY cycle 10 of a DIVU -> next cycle state IDLE, out_valid=0, result=0. A following ADD 2+3 -> 5 with normal 1-edge latency.
